// File: rtl/cal_pulse_gen_if.sv
// rtl/cal_pulse_gen_if.sv - control/config/status bundle for the calibration pulse generator
interface cal_pulse_gen_if #(
    parameter int CNT_WIDTH = 32
);
    // Control strobes from the register bank.
    logic                 start;
    logic                 stop;

    // Run configuration, sampled only when a run is accepted.
    logic [CNT_WIDTH-1:0] pulse_width;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] n_pulses;
    logic [CNT_WIDTH-1:0] trig_delay;
    logic                 trig_en;

    // Generated waveform and status.
    logic                 cal_pulse;
    logic                 trig_out;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] pulse_count;

    // Register bank / test driver side.
    modport master (
        output start,
        output stop,
        output pulse_width,
        output period,
        output n_pulses,
        output trig_delay,
        output trig_en,
        input  cal_pulse,
        input  trig_out,
        input  busy,
        input  done,
        input  pulse_count
    );

    // Pulse generator side.
    modport slave (
        input  start,
        input  stop,
        input  pulse_width,
        input  period,
        input  n_pulses,
        input  trig_delay,
        input  trig_en,
        output cal_pulse,
        output trig_out,
        output busy,
        output done,
        output pulse_count
    );
endinterface

// File: rtl/cal_pulse_gen.sv
// rtl/cal_pulse_gen.sv - programmable calibration pulse train with delayed trigger
module cal_pulse_gen #(
    parameter int CNT_WIDTH = 32
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    cal_pulse_gen_if.slave bus
);
    localparam int CW = CNT_WIDTH;

    localparam logic [CW-1:0] ZERO    = '0;
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   ONE_EXT = {{CW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // Position within the current pulse period, 0 .. P-1. HIGH covers 0 .. W-1.
    logic [CW-1:0] pos_q, pos_d;
    logic [CW-1:0] pulse_count_q, pulse_count_d;

    // Configuration captured at start so register writes mid-run are harmless.
    logic [CW-1:0] sh_width_q,   sh_width_d;
    logic [CW-1:0] sh_period_q,  sh_period_d;
    logic [CW-1:0] sh_npulses_q, sh_npulses_d;
    logic [CW-1:0] sh_tdelay_q,  sh_tdelay_d;
    logic          sh_trig_en_q, sh_trig_en_d;

    logic          cal_pulse_q, cal_pulse_d;
    logic          trig_out_q,  trig_out_d;
    logic          done_q,      done_d;
    logic          busy_q,      busy_d;

    logic          accept;

    // Effective high time and period, one bit wider so W+1 cannot wrap.
    logic [CW:0]   w_ext;
    logic [CW:0]   p_ext;
    logic          last_high;
    logic          last_low;
    logic          run_complete;
    logic          trig_armed;

    // Accept a start only from IDLE and only when stop is not also asserted.
    always_comb begin
        accept       = (state_q == ST_IDLE) && bus.start && !bus.stop;
        sh_width_d   = sh_width_q;
        sh_period_d  = sh_period_q;
        sh_npulses_d = sh_npulses_q;
        sh_tdelay_d  = sh_tdelay_q;
        sh_trig_en_d = sh_trig_en_q;
        if (accept) begin
            sh_width_d   = bus.pulse_width;
            sh_period_d  = bus.period;
            sh_npulses_d = bus.n_pulses;
            sh_tdelay_d  = bus.trig_delay;
            sh_trig_en_d = bus.trig_en;
        end
    end

    // Clamp W to at least 1 and P to at least W+1 so LOW always lasts a cycle.
    always_comb begin
        w_ext = (sh_width_d == ZERO) ? ONE_EXT : {1'b0, sh_width_d};
        p_ext = ({1'b0, sh_period_d} > w_ext) ? {1'b0, sh_period_d} : (w_ext + ONE_EXT);
        last_high    = ({1'b0, pos_q} == (w_ext - ONE_EXT));
        last_low     = ({1'b0, pos_q} == (p_ext - ONE_EXT));
        run_complete = (sh_npulses_q != ZERO) && (pulse_count_q == sh_npulses_q);
        trig_armed   = sh_trig_en_d && ({1'b0, sh_tdelay_d} < p_ext);
    end

    // Next-state, phase position and pulse counting; stop wins over everything.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        pulse_count_d = pulse_count_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d       = ST_HIGH;
                    pos_d         = ZERO;
                    pulse_count_d = ONE;
                end
            end
            ST_HIGH: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    pos_d = pos_q + ONE;
                    if (last_high) begin
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (last_low) begin
                    if (run_complete) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ST_HIGH;
                        pos_d         = ZERO;
                        pulse_count_d = pulse_count_q + ONE;
                    end
                end else begin
                    pos_d = pos_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flop inputs derived from the next state so outputs line up with it.
    always_comb begin
        cal_pulse_d = (state_d == ST_HIGH);
        busy_d      = (state_d != ST_IDLE);
        trig_out_d  = busy_d && trig_armed && (pos_d == sh_tdelay_d);
    end

    // Single state register bank; reset aborts silently and clears the shadows.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            pos_q         <= '0;
            pulse_count_q <= '0;
            sh_width_q    <= '0;
            sh_period_q   <= '0;
            sh_npulses_q  <= '0;
            sh_tdelay_q   <= '0;
            sh_trig_en_q  <= 1'b0;
            cal_pulse_q   <= 1'b0;
            trig_out_q    <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            pulse_count_q <= pulse_count_d;
            sh_width_q    <= sh_width_d;
            sh_period_q   <= sh_period_d;
            sh_npulses_q  <= sh_npulses_d;
            sh_tdelay_q   <= sh_tdelay_d;
            sh_trig_en_q  <= sh_trig_en_d;
            cal_pulse_q   <= cal_pulse_d;
            trig_out_q    <= trig_out_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cal_pulse   = cal_pulse_q;
    assign bus.trig_out    = trig_out_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.pulse_count = pulse_count_q;
endmodule

// File: tb/tb_cal_pulse_gen.sv
// tb/tb_cal_pulse_gen.sv - scoreboard bench for cal_pulse_gen
module tb_cal_pulse_gen;
    localparam int CW = 8;

    typedef struct packed {
        logic          cal;
        logic          trig;
        logic          done;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic ACLK;
    logic ARESETN;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    exp_t e;
    exp_t zero_e;

    cal_pulse_gen_if #(.CNT_WIDTH(CW)) bus ();

    cal_pulse_gen #(.CNT_WIDTH(CW)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic exp_t obs();
        return {bus.cal_pulse, bus.trig_out, bus.done, bus.busy, bus.pulse_count};
    endfunction

    task automatic set_cfg(input int pw, input int per, input int np, input int td, input bit en);
        bus.pulse_width = pw[CW-1:0];
        bus.period      = per[CW-1:0];
        bus.n_pulses    = np[CW-1:0];
        bus.trig_delay  = td[CW-1:0];
        bus.trig_en     = en;
    endtask

    // Expected output stream, index 0 = first cycle after the accepting edge.
    task automatic gen_expected(input int pw, input int per, input int np, input int td,
                                input bit en, input int ncyc, input int stop_idx);
        int   w, p, cnt, pos;
        bit   ended;
        exp_t x;
        w     = (pw == 0) ? 1 : pw;
        p     = (per > w) ? per : w + 1;
        ended = 1'b0;
        cnt   = 0;
        for (int j = 0; j < ncyc; j++) begin
            if (!ended && (j == stop_idx || (np != 0 && j == np * p))) begin
                x = '0;
                x.done = 1'b1;
                x.cnt  = cnt[CW-1:0];
                ended  = 1'b1;
            end else if (ended) begin
                x = '0;
                x.cnt = cnt[CW-1:0];
            end else begin
                pos    = j % p;
                cnt    = (j / p + 1) % (1 << CW);
                x.cal  = (pos < w);
                x.trig = en && (td < p) && (pos == td);
                x.done = 1'b0;
                x.busy = 1'b1;
                x.cnt  = cnt[CW-1:0];
            end
            exp_q.push_back(x);
        end
    endtask

    task automatic test_reset();
        @(negedge ACLK);
        exp_q.push_back(zero_e);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_state got=%h expected=%h", obs(), e);
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
        exp_q.push_back(zero_e);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL reset_release got=%h expected=%h", obs(), e);
        end
    endtask

    task automatic test_idle_ignored();
        set_cfg(2, 5, 1, 0, 1'b1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        for (int j = 0; j < 6; j++) exp_q.push_back(zero_e);
        for (int j = 0; j < 6; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL idle_ignored idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = (j < 1);
            bus.stop  = (j < 1) || (j == 3);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic test_basic();
        set_cfg(3, 10, 4, 5, 1'b1);
        bus.start = 1'b1;
        gen_expected(3, 10, 4, 5, 1'b1, 45, -1);
        for (int j = 0; j < 45; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL basic idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_min_width();
        set_cfg(0, 0, 2, 0, 1'b1);
        bus.start = 1'b1;
        gen_expected(0, 0, 2, 0, 1'b1, 8, -1);
        for (int j = 0; j < 8; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL min_width idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_stop_continuous();
        set_cfg(3, 8, 0, 2, 1'b1);
        bus.start = 1'b1;
        gen_expected(3, 8, 0, 2, 1'b1, 22, 17);
        for (int j = 0; j < 22; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL stop_continuous idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
            bus.stop  = (j == 16);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_trig_suppress();
        set_cfg(3, 10, 2, 12, 1'b1);
        bus.start = 1'b1;
        gen_expected(3, 10, 2, 12, 1'b1, 23, -1);
        for (int j = 0; j < 23; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL trig_too_late idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
        set_cfg(3, 10, 2, 2, 1'b0);
        bus.start = 1'b1;
        gen_expected(3, 10, 2, 2, 1'b0, 23, -1);
        for (int j = 0; j < 23; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL trig_disabled idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
    endtask

    task automatic test_shadow();
        set_cfg(3, 10, 2, 1, 1'b1);
        bus.start = 1'b1;
        gen_expected(3, 10, 2, 1, 1'b1, 23, -1);
        for (int j = 0; j < 23; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL shadow idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = (j == 4);
            if (j == 4) set_cfg(6, 4, 7, 0, 1'b0);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_stop_at_completion();
        set_cfg(1, 4, 2, 0, 1'b1);
        bus.start = 1'b1;
        gen_expected(1, 4, 2, 0, 1'b1, 12, 8);
        for (int j = 0; j < 12; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL stop_at_completion idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
            bus.stop  = (j == 7) || (j == 10);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_wrap();
        set_cfg(0, 0, 0, 1, 1'b1);
        bus.start = 1'b1;
        gen_expected(0, 0, 0, 1, 1'b1, 522, 519);
        for (int j = 0; j < 522; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL wrap idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
            bus.stop  = (j == 518);
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        set_cfg(3, 10, 3, 1, 1'b1);
        bus.start = 1'b1;
        gen_expected(3, 10, 3, 1, 1'b1, 6, -1);
        for (int j = 0; j < 6; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL pre_reset idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
        #2 ARESETN = 1'b0;
        #1;
        exp_q.push_back(zero_e);
        e = exp_q.pop_front();
        n_checks++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL async_reset got=%h expected=%h", obs(), e);
        end
        for (int j = 0; j < 5; j++) exp_q.push_back(zero_e);
        for (int j = 0; j < 5; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL post_reset_idle idx=%0d got=%h expected=%h", j, obs(), e);
            end
            ARESETN = 1'b1;
        end
        set_cfg(1, 4, 1, 0, 1'b1);
        bus.start = 1'b1;
        gen_expected(1, 4, 1, 0, 1'b1, 7, -1);
        for (int j = 0; j < 7; j++) begin
            @(negedge ACLK);
            e = exp_q.pop_front();
            n_checks++;
            if (obs() !== e) begin
                n_fail++;
                $display("FAIL rerun idx=%0d got=%h expected=%h", j, obs(), e);
            end
            bus.start = 1'b0;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        zero_e    = '0;
        ARESETN   = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        @(negedge ACLK);
        test_reset();
        test_idle_ignored();
        test_basic();
        test_min_width();
        test_stop_continuous();
        test_trig_suppress();
        test_shadow();
        test_stop_at_completion();
        test_wrap();
        test_reset_mid_run();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cal_pulse_gen.md
CAL_PULSE_GEN -- requirements
Module: cal_pulse_gen

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of all timing and count fields.
REQ-002 SHALL have port ACLK  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port ARESETN  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle strobe from the AXI register bank control write.
REQ-005 SHALL have port stop  input  1  one-cycle strobe; aborts the running sequence.
REQ-006 SHALL have port pulse_width  input  CNT_WIDTH  high time in ACLK cycles.
REQ-007 SHALL have port period  input  CNT_WIDTH  rising-edge-to-rising-edge spacing in cycles.
REQ-008 SHALL have port n_pulses  input  CNT_WIDTH  pulses per run; 0 = continuous until stop.
REQ-009 SHALL have port trig_delay  input  CNT_WIDTH  cycles from cal_pulse rising edge to trig_out.
REQ-010 SHALL have port trig_en  input  1  enables trig_out generation.
REQ-011 SHALL have port cal_pulse  output  1  registered calibration pulse to the ASIC front end.
REQ-012 SHALL have port trig_out  output  1  registered one-cycle delayed trigger.
REQ-013 SHALL have port busy  output  1  high while state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle strobe when a run ends (completion or stop).
REQ-015 SHALL have port pulse_count  output  CNT_WIDTH  rising edges issued in current/last run.

Function
REQ-016 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-017 SHALL latch pulse_width, period, n_pulses, trig_delay, trig_en into shadow registers on the cycle start is accepted; later input changes SHALL NOT affect the run.
REQ-018 SHALL define W = max(pulse_width,1) and P = max(period, W+1) from shadow values.
REQ-019 IDLE: start=1 and stop=0 -> HIGH next cycle; pulse_count cleared to 1 in that transition; cal_pulse=1 from the first HIGH cycle.
REQ-020 HIGH SHALL last exactly W cycles with cal_pulse=1, then -> LOW.
REQ-021 LOW SHALL last exactly P-W cycles with cal_pulse=0.
REQ-022 End of LOW: if n_pulses!=0 and pulse_count==n_pulses -> IDLE with done=1 for one cycle; else -> HIGH and pulse_count increments by 1.
REQ-023 pulse_count SHALL wrap modulo 2^CNT_WIDTH in continuous mode.
REQ-024 trig_out SHALL pulse for one cycle exactly trig_delay cycles after the first HIGH cycle of each pulse (trig_delay=0 -> coincident with first HIGH cycle), only if trig_en latched =1 and trig_delay < P; otherwise suppressed for that pulse.
REQ-025 stop=1 in HIGH or LOW -> IDLE next cycle, cal_pulse=0, pending trig_out cancelled, done=1 one cycle; pulse_count holds.
REQ-026 stop=1 in IDLE SHALL be ignored (no done); stop and start together in IDLE SHALL be ignored.
REQ-027 start while busy SHALL be ignored.
REQ-028 Stop coinciding with natural completion SHALL produce exactly one done.
REQ-029 cal_pulse, trig_out, done SHALL be driven from flops; no combinational path from inputs.

Reset
REQ-030 ARESETN=0 SHALL asynchronously force state IDLE, cal_pulse=0, trig_out=0, busy=0, done=0, pulse_count=0, shadow registers 0.
REQ-031 Reset asserted mid-run SHALL abort with no done strobe; deassertion SHALL require a new start.

Verification
REQ-032 pulse_width=3, period=10, n_pulses=4, trig_delay=5, trig_en=1, start -> 4 pulses, 3 high/7 low each, trig_out 5 cycles after each rising edge, done once, pulse_count=4.
REQ-033 pulse_width=0, period=0, n_pulses=2 -> W=1, P=2: cal_pulse 1,0,1,0 then done; pulse_count=2.
REQ-034 n_pulses=0, period=8, stop during 3rd HIGH -> cal_pulse low next cycle, done once, pulse_count=3, no trig_out after stop.
REQ-035 trig_delay=12, period=10 -> no trig_out during the run; trig_en=0 with trig_delay=2 -> no trig_out.
REQ-036 Change pulse_width 3->6 and assert start mid-run -> run continues with width 3, start ignored.
REQ-037 ARESETN low during LOW phase -> all outputs 0 immediately, no done; subsequent start runs normally from pulse_count=1.
